// File: rtl/nf_seven_seg_pkg.sv
// rtl/nf_seven_seg_pkg.sv - shared constants for the seven-segment scanner
package nf_seven_seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam int BRIGHT_W = 4;

  // Active-high hex glyphs, bit SEG_A..SEG_G
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/nf_seven_seg_decoder.sv
// rtl/nf_seven_seg_decoder.sv - nibble to seven-segment glyph lookup
module nf_seven_seg_decoder
  import nf_seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/nf_seven_seg_scan.sv
// rtl/nf_seven_seg_scan.sv - multiplexed hex display scanner with PWM and frame snapshots
module nf_seven_seg_scan
  import nf_seven_seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   hex,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   bright,
  input  logic                  cc_ca,
  output logic [7:0]            seven_seg,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_done
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [PRE_W-1:0]    pre;
  logic [IDX_W-1:0]    idx;
  logic [BRIGHT_W-1:0] phase;
  logic [4*DIGITS-1:0] shadow_hex;
  logic [DIGITS-1:0]   shadow_dp;
  logic [7:0]          raw_seg;
  logic [DIGITS-1:0]   raw_dig;

  logic                tick;
  logic                frame_wrap;
  logic                digit_on;
  logic [DIGITS-1:0]   upper_zero;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic [6:0]          glyph;
  logic [7:0]          seg_next;
  logic [DIGITS-1:0]   dig_next;

  assign tick       = (pre == PRE_LAST);
  assign frame_wrap = tick && (idx == IDX_LAST);
  // First clock of each slot stays dark so the digit switch never ghosts
  assign digit_on   = (phase <= bright) && (pre != '0);

  // upper_zero[i]: nibbles i..DIGITS-1 of the frame are all zero
  always_comb begin
    upper_zero = '0;
    for (int i = 0; i < DIGITS; i++) begin
      upper_zero[i] = ((shadow_hex >> (4 * i)) == '0);
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = shadow_hex[4*i +: 4];
        cur_dp    = shadow_dp[i];
        cur_blank = blank_lz && (i != 0) && upper_zero[i];
      end
    end
  end

  nf_seven_seg_decoder u_decoder (
    .nibble (cur_nib),
    .glyph  (glyph)
  );

  always_comb begin
    seg_next                = '0;
    seg_next[SEG_G:SEG_A]   = cur_blank ? 7'h00 : glyph;
    seg_next[SEG_DP]        = cur_dp;
    dig_next                = DIGITS'(1) << idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre        <= '0;
      idx        <= '0;
      phase      <= '0;
      shadow_hex <= '0;
      shadow_dp  <= '0;
      raw_seg    <= '0;
      raw_dig    <= '0;
      frame_done <= 1'b0;
    end else begin
      pre   <= tick ? '0 : pre + 1'b1;
      phase <= phase + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      // Snapshot only at frame wrap so one frame never mixes two values
      if (frame_wrap) begin
        shadow_hex <= hex;
        shadow_dp  <= dp;
      end
      frame_done <= frame_wrap;
      raw_seg    <= digit_on ? seg_next : '0;
      raw_dig    <= digit_on ? dig_next : '0;
    end
  end

  assign seven_seg = raw_seg ^ {8{cc_ca}};
  assign dig       = cc_ca ? raw_dig : ~raw_dig;

endmodule

// File: tb/tb_nf_seven_seg_scan.sv
// tb/tb_nf_seven_seg_scan.sv - randomized and directed bench for nf_seven_seg_scan
`timescale 1ns/1ps
module tb_nf_seven_seg_scan;

  localparam int CFG_D  [3] = '{4, 4, 1};
  localparam int CFG_RD [3] = '{4, 64, 4};
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] hex = '0;
  logic [3:0]  dp = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  bright = 4'd15;
  logic        cc_ca = 1'b0;

  logic [7:0] seg0, seg_b, seg_1;
  logic [3:0] dig0, dig_b;
  logic       dig_1;
  logic       fd0, fd_b, fd_1;

  int checks = 0;
  int errors = 0;

  int          m_n  [3];
  logic [15:0] m_sh [3];
  logic [3:0]  m_dp [3];

  always #5 clk = ~clk;

  nf_seven_seg_scan #(.DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .hex(hex), .dp(dp), .blank_lz(blank_lz),
    .bright(bright), .cc_ca(cc_ca), .seven_seg(seg0), .dig(dig0), .frame_done(fd0));

  nf_seven_seg_scan #(.DIGITS(4), .REFRESH_DIV(64)) dut_b (
    .clk(clk), .rst(rst), .hex(hex), .dp(dp), .blank_lz(blank_lz),
    .bright(bright), .cc_ca(cc_ca), .seven_seg(seg_b), .dig(dig_b), .frame_done(fd_b));

  nf_seven_seg_scan #(.DIGITS(1), .REFRESH_DIV(4)) dut_1 (
    .clk(clk), .rst(rst), .hex(hex[3:0]), .dp(dp[0]), .blank_lz(blank_lz),
    .bright(bright), .cc_ca(cc_ca), .seven_seg(seg_1), .dig(dig_1), .frame_done(fd_1));

  // Display content for the n-th clock after reset, derived from slot arithmetic
  function automatic logic [11:0] model_raw(int c, int n, logic [15:0] sh, logic [3:0] sdp);
    int d, rd, pre, idx, ph;
    logic [7:0] seg;
    logic [3:0] dg, nib;
    d   = CFG_D[c];
    rd  = CFG_RD[c];
    pre = n % rd;
    idx = (n / rd) % d;
    ph  = n % 16;
    seg = '0;
    dg  = '0;
    if (ph <= int'(bright) && pre != 0) begin
      nib      = 4'((sh >> (4 * idx)) & 16'hF);
      seg[6:0] = GLYPHS[nib];
      if (blank_lz && idx > 0 && (sh >> (4 * idx)) == 16'h0) seg[6:0] = 7'h00;
      seg[7]   = sdp[idx];
      dg       = 4'(1 << idx);
    end
    return {seg, dg};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_n[c]  = 0;
      m_sh[c] = '0;
      m_dp[c] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step();
    logic [11:0] r;
    logic [7:0]  eseg [3];
    logic [3:0]  edig [3];
    logic        efd  [3];
    for (int c = 0; c < 3; c++) begin
      r       = model_raw(c, m_n[c], m_sh[c], m_dp[c]);
      eseg[c] = r[11:4] ^ {8{cc_ca}};
      edig[c] = cc_ca ? r[3:0] : ~r[3:0];
      efd[c]  = ((m_n[c] + 1) % (CFG_D[c] * CFG_RD[c])) == 0;
      if (efd[c]) begin
        m_sh[c] = (c == 2) ? (hex & 16'h000F) : hex;
        m_dp[c] = (c == 2) ? (dp & 4'h1) : dp;
      end
      m_n[c]++;
    end
    @(posedge clk);
    #1;
    checks += 9;
    if (seg0 !== eseg[0]) begin errors++; $display("FAIL model_seg n=%0d got %h exp %h", m_n[0], seg0, eseg[0]); end
    if (dig0 !== edig[0]) begin errors++; $display("FAIL model_dig n=%0d got %b exp %b", m_n[0], dig0, edig[0]); end
    if (fd0 !== efd[0]) begin errors++; $display("FAIL model_fd n=%0d got %b exp %b", m_n[0], fd0, efd[0]); end
    if (seg_b !== eseg[1]) begin errors++; $display("FAIL model_seg_b n=%0d got %h exp %h", m_n[1], seg_b, eseg[1]); end
    if (dig_b !== edig[1]) begin errors++; $display("FAIL model_dig_b n=%0d got %b exp %b", m_n[1], dig_b, edig[1]); end
    if (fd_b !== efd[1]) begin errors++; $display("FAIL model_fd_b n=%0d got %b exp %b", m_n[1], fd_b, efd[1]); end
    if (seg_1 !== eseg[2]) begin errors++; $display("FAIL model_seg_1 n=%0d got %h exp %h", m_n[2], seg_1, eseg[2]); end
    if (dig_1 !== edig[2][0]) begin errors++; $display("FAIL model_dig_1 n=%0d got %b exp %b", m_n[2], dig_1, edig[2][0]); end
    if (fd_1 !== efd[2]) begin errors++; $display("FAIL model_fd_1 n=%0d got %b exp %b", m_n[2], fd_1, efd[2]); end
  endtask

  task automatic run_to(int target);
    int guard = 0;
    while (m_n[0] < target && guard < 2000) begin
      step();
      guard++;
    end
    checks++;
    if (m_n[0] != target) begin
      errors++;
      $display("FAIL run_to reached %0d need %0d", m_n[0], target);
    end
  endtask

  // Clocks after reset at which slot k (pre=1) of the second frame is visible
  task automatic check_frame(string name, logic [7:0] exp_seg [4], logic [3:0] exp_dig [4]);
    for (int k = 0; k < 4; k++) begin
      run_to(18 + 4 * k);
      checks += 2;
      if (seg0 !== exp_seg[k]) begin errors++; $display("FAIL %s_seg slot%0d got %h exp %h", name, k, seg0, exp_seg[k]); end
      if (dig0 !== exp_dig[k]) begin errors++; $display("FAIL %s_dig slot%0d got %b exp %b", name, k, dig0, exp_dig[k]); end
    end
  endtask

  task automatic test_reset();
    #2;
    checks += 6;
    if (seg0 !== 8'h00) begin errors++; $display("FAIL reset_seg_cc got %h exp 00", seg0); end
    if (dig0 !== 4'hF) begin errors++; $display("FAIL reset_dig_cc got %b exp 1111", dig0); end
    if (fd0 !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", fd0); end
    cc_ca = 1'b1;
    #1;
    if (seg0 !== 8'hFF) begin errors++; $display("FAIL reset_seg_ca got %h exp ff", seg0); end
    if (dig0 !== 4'h0) begin errors++; $display("FAIL reset_dig_ca got %b exp 0000", dig0); end
    if (dig_1 !== 1'b0) begin errors++; $display("FAIL reset_dig1_ca got %b exp 0", dig_1); end
    cc_ca = 1'b0;
    hex = 16'h1A8F;
    do_reset();
    run_to(2);
    checks++;
    if (seg0 !== 8'h3F) begin errors++; $display("FAIL first_frame_zero got %h exp 3f", seg0); end
  endtask

  task automatic test_basic_scan();
    logic [7:0] es [4] = '{8'h71, 8'h7F, 8'h77, 8'h06};
    logic [3:0] ed [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    hex = 16'h1A8F; dp = 4'h0; bright = 4'd15; cc_ca = 1'b0; blank_lz = 1'b0;
    do_reset();
    run_to(16);
    checks++;
    if (fd0 !== 1'b1) begin errors++; $display("FAIL first_frame_done got %b exp 1", fd0); end
    run_to(17);
    checks += 2;
    if (seg0 !== 8'h00) begin errors++; $display("FAIL basic_dark_seg got %h exp 00", seg0); end
    if (dig0 !== 4'hF) begin errors++; $display("FAIL basic_dark_dig got %b exp 1111", dig0); end
    check_frame("basic", es, ed);
  endtask

  task automatic test_common_anode();
    logic [7:0] es [4] = '{8'h8E, 8'h80, 8'h88, 8'hF9};
    logic [3:0] ed [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    hex = 16'h1A8F; dp = 4'h0; bright = 4'd15; cc_ca = 1'b1; blank_lz = 1'b0;
    do_reset();
    run_to(17);
    checks += 2;
    if (seg0 !== 8'hFF) begin errors++; $display("FAIL ca_dark_seg got %h exp ff", seg0); end
    if (dig0 !== 4'h0) begin errors++; $display("FAIL ca_dark_dig got %b exp 0000", dig0); end
    check_frame("ca", es, ed);
    cc_ca = 1'b0;
  endtask

  task automatic test_blanking();
    logic [7:0] es [4] = '{8'h3F, 8'h4F, 8'h00, 8'h80};
    logic [3:0] ed [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    hex = 16'h0030; dp = 4'b1000; bright = 4'd15; cc_ca = 1'b0; blank_lz = 1'b1;
    do_reset();
    check_frame("lz", es, ed);
    blank_lz = 1'b0;
    dp = 4'h0;
  endtask

  task automatic test_brightness();
    int on_cnt;
    logic [3:0] levels [2] = '{4'd3, 4'd0};
    int         expect_on [2] = '{15, 3};
    for (int l = 0; l < 2; l++) begin
      bright = levels[l];
      hex = 16'h8888;
      do_reset();
      on_cnt = 0;
      for (int j = 0; j < 128; j++) begin
        step();
        if (m_n[1] > 64 && dig_b !== 4'hF) on_cnt++;
      end
      checks++;
      if (on_cnt != expect_on[l]) begin
        errors++;
        $display("FAIL bright%0d_on_count got %0d exp %0d", levels[l], on_cnt, expect_on[l]);
      end
    end
    bright = 4'd15;
  endtask

  task automatic test_tear_free();
    hex = 16'h1111; dp = 4'h0; bright = 4'd15; cc_ca = 1'b0; blank_lz = 1'b0;
    do_reset();
    run_to(25);
    hex = 16'h2222;
    run_to(26);
    checks++;
    if (seg0 !== 8'h06) begin errors++; $display("FAIL tear_digit2 got %h exp 06", seg0); end
    run_to(30);
    checks++;
    if (seg0 !== 8'h06) begin errors++; $display("FAIL tear_digit3 got %h exp 06", seg0); end
    run_to(34);
    checks++;
    if (seg0 !== 8'h5B) begin errors++; $display("FAIL tear_new_frame got %h exp 5b", seg0); end
  endtask

  task automatic test_reset_mid_frame();
    hex = 16'h1A8F; bright = 4'd15; cc_ca = 1'b0;
    do_reset();
    run_to(30);
    checks++;
    if (dig0 !== 4'b0111) begin errors++; $display("FAIL midrst_pre_dig got %b exp 0111", dig0); end
    #2;
    rst = 1'b1;
    #1;
    checks += 3;
    if (dig0 !== 4'hF) begin errors++; $display("FAIL midrst_dig got %b exp 1111", dig0); end
    if (seg0 !== 8'h00) begin errors++; $display("FAIL midrst_seg got %h exp 00", seg0); end
    if (fd0 !== 1'b0) begin errors++; $display("FAIL midrst_fd got %b exp 0", fd0); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run_to(2);
    checks++;
    if (dig0 !== 4'b1110) begin errors++; $display("FAIL midrst_restart_dig got %b exp 1110", dig0); end
  endtask

  task automatic test_single_digit();
    int pulses = 0;
    hex = 16'h0005;
    do_reset();
    for (int j = 0; j < 40; j++) begin
      step();
      if (fd_1 === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 10) begin errors++; $display("FAIL d1_frame_pulses got %0d exp 10", pulses); end
  endtask

  task automatic test_random();
    do_reset();
    for (int j = 0; j < 600; j++) begin
      bright = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 6) == 0) begin
        hex = 16'($urandom);
        if ($urandom_range(0, 2) == 0) hex[15:8] = 8'h00;
        dp = 4'($urandom);
      end
      if (j % 100 == 0) begin
        blank_lz = 1'($urandom);
        cc_ca    = 1'($urandom);
      end
      step();
    end
    cc_ca = 1'b0;
    blank_lz = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_scan();
    test_common_anode();
    test_blanking();
    test_brightness();
    test_tear_free();
    test_reset_mid_frame();
    test_single_digit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
